// File: rtl/pipe_register.sv
// Elastic pipeline register: STAGES-deep valid/ready chain with bubble collapsing,
// synchronous flush and an occupancy count.
module pipe_register #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       STAGES    = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out,
  output logic [$clog2(STAGES+1)-1:0]  count
);

  localparam int unsigned CountW = $clog2(STAGES + 1);

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [STAGES:0]   r;

  // A stage may advance when it is empty or its successor is advancing.
  always_comb begin
    r         = '0;
    r[STAGES] = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      r[i] = !v_q[i] | r[i+1];
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (r[0]) begin
        d_d[0] = in;
        v_d[0] = in_valid;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (r[i]) begin
          d_d[i] = d_q[i-1];
          v_d[i] = v_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        d_q[i] <= RESET_VAL;
      end
    end else begin
      v_q <= v_d;
      for (int unsigned i = 0; i < STAGES; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      count = count + CountW'(v_q[i]);
    end
  end

  assign in_ready  = r[0] & !flush;
  assign out_valid = v_q[STAGES-1] & !flush;
  assign out       = d_q[STAGES-1];

endmodule

// File: doc/pipe_register.md
Name: pipe_register

Overview:
- Parametrised, elastic successor to the plain load-enabled register, used between CPU pipeline stages.
- Provides a chain of STAGES data registers with valid/ready handshake and bubble collapsing.
- Adds synchronous flush for branch/exception squash, plus an occupancy count.
- Sits between the fetch/decode/execute/memory/writeback stage boundaries of the RISC-V core.

Parameters:
- WIDTH, 32, data bits per stage.
- STAGES, 1, number of register stages; legal range 1..8.
- RESET_VAL, 0 (WIDTH bits), value loaded into every data register on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all stages.
- in_valid  input  1  upstream presents data.
- in_ready  output  1  block accepts data this cycle.
- in  input  WIDTH  upstream data.
- out_valid  output  1  stage STAGES-1 holds valid data.
- out_ready  input  1  downstream accepts data this cycle.
- out  output  WIDTH  data of stage STAGES-1.
- count  output  $clog2(STAGES+1)  number of valid stages.

Behaviour:
- One clock, clk; reset is asynchronous and active-low on rst_n.
- State per stage i (0..STAGES-1): v[i] and d[i].
- On rst_n=0, immediately and independent of clk: v[i]=0 and d[i]=RESET_VAL. Outputs during reset: out_valid=0, out=RESET_VAL, count=0, in_ready=1 unless flush=1.
- Ready chain is combinational:
  - r[STAGES] = out_ready.
  - r[i] = !v[i] | r[i+1].
- in_ready = r[0] & !flush.
- out_valid = v[STAGES-1] & !flush.
- out = d[STAGES-1] at all times. No combinational path from in to out.
- Per rising edge, with flush=0 and rst_n=1, for each stage i where r[i]=1:
  - Stage 0 loads in and v[0]=in_valid.
  - Stage i>0 loads d[i-1] and v[i]=v[i-1].
  - Stages with r[i]=0 hold both d and v.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Latency: an accepted word appears on out exactly STAGES cycles later if no stall occurs.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Bubble collapse: an empty stage always accepts from its predecessor, even when downstream is stalled. With STAGES valid words and out_ready=0, in_ready=0.
- flush=1 at an edge:
  - All v[i] clear to 0; d[i] hold.
  - No input or output transfer occurs in the flush cycle; in_valid is ignored.
  - count reads 0 on the following cycle.
- Reset versus flush: rst_n=0 overrides flush and all handshakes. Reset asserted mid-stream discards all in-flight words.
- count = popcount of v[], registered-state based. It updates on the edge after a transfer.
- Data is captured only on a stage advance. A stalled out is stable and must not change while out_valid=1 and out_ready=0.
- STAGES=1 behaves as a single-entry register:
  - in_ready = !v[0] | out_ready.
  - With out_ready=1, a load every cycle.
- in_valid=0 with r[0]=1 writes a bubble: v[0]=0, and d[0] captures in regardless.
- No X propagation is permitted on out_valid, in_ready or count after reset.

Test Plan:
- Reset, WIDTH=32, STAGES=3, RESET_VAL=32'hDEAD_BEEF: assert rst_n=0 mid-cycle → out=32'hDEAD_BEEF, out_valid=0, count=0 immediately, without a clock edge.
- Streaming: out_ready=1, push 1,2,3,4,5 on consecutive cycles → out_valid first high 3 cycles after word 1, out=1,2,3,4,5 on consecutive cycles, in_ready stays 1.
- Backpressure: out_ready=0, push 10,11,12,13 → 10,11,12 accepted, in_ready=0 when 13 is offered, count=3, out holds 10. Raise out_ready for 4 cycles → out=10,11,12,13 in order, no loss or duplication.
- Bubble collapse: push A, two idle cycles, push B, with out_ready=0 → count=2, out=A, B held in stage 1, in_ready=1.
- Flush: with count=3, out_ready=1, flush=1 for one cycle and in_valid=1 with 77 → no output transfer that cycle, 77 not captured, count=0 next cycle, out_valid=0 until new data arrives.
- STAGES=1, WIDTH=8: push 8'h5A with out_ready=0 → in_ready=0 the next cycle. Then out_ready=1 and in 8'hA5 in the same cycle → 5A delivered and A5 loaded on the same edge.
